// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the writeback entry type
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries with occupancy count
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  wb_entry_t   din,
    input  logic        pop,
    output wb_entry_t   dout,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    wb_entry_t     mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: merges ALU and load results onto one regfile write port and keeps the busy scoreboard
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int NREG       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        chk_rs1,
    input  logic [4:0]        chk_rs2,
    input  logic [4:0]        chk_rd,
    output logic              stall,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              rf_we,
    output logic [4:0]        rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [NREG-1:0]   busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t       head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            alu_wr;
    logic            push;
    logic            pop;
    logic [NREG-1:0] busy_nxt;

    // a full FIFO blocks both producers so it gets a drain cycle
    assign alu_ready = !fifo_full;
    assign ld_ready  = !fifo_full;
    assign alu_wr    = alu_valid && !fifo_full && alu_rd != '0;
    assign push      = ld_valid && !fifo_full && ld_rd != '0;
    assign pop       = !alu_wr && !fifo_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({ld_rd, ld_data}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    ast_count: assert property (@(posedge clk) disable iff (!reset) fifo_empty == (fifo_count == '0));

    // register the selected result; ALU has priority over the FIFO head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= alu_wr || pop;
            if (alu_wr) {rf_rd, rf_wdata} <= {alu_rd, alu_data};
            else if (pop) {rf_rd, rf_wdata} <= head;
        end
    end

    // commit clears, issue sets, and a same-edge set overrides the clear
    always_comb begin
        busy_nxt = busy;
        if (rf_we) busy_nxt[rf_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // scoreboard state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else busy <= busy_nxt;
    end

    // hazard check against operands currently in decode
    always_comb begin
        stall = (busy[chk_rs1] && chk_rs1 != '0) || (busy[chk_rs2] && chk_rs2 != '0) ||
                (busy[chk_rd] && chk_rd != '0);
    end
endmodule
